// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter between two byte requesters.
// Sequences Tx_WR/Tx_EN/Tx_BUSY, acks or errors the winner, and freezes baud_select mid-frame.
module uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic [2:0] baud_cfg,
    input  logic       Tx_BUSY,
    output logic [7:0] Tx_DATA,
    output logic       Tx_WR,
    output logic       Tx_EN,
    output logic [2:0] baud_select,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StWaitStart,
        StSending,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(START_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_wr_q, tx_wr_d;
    logic             tx_en_q, tx_en_d;
    logic [2:0]       baud_q, baud_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_wr_d      = tx_wr_q;
        tx_en_d      = tx_en_q;
        baud_d       = baud_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = baud_cfg;
                // A stale frame still on the wire blocks arbitration.
                if (!Tx_BUSY && (req0 || req1)) begin
                    grant_d      = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant_d;
                    state_d      = StArb;
                end
            end
            StArb: begin
                tx_data_d = grant_q ? data1 : data0;
                tx_en_d   = 1'b1;
                tx_wr_d   = 1'b1;
                cnt_d     = '0;
                state_d   = StWaitStart;
            end
            StWaitStart: begin
                if (Tx_BUSY) begin
                    tx_wr_d = 1'b0;
                    state_d = StSending;
                end else if (cnt_q == TimeoutLast) begin
                    tx_wr_d = 1'b0;
                    tx_en_d = 1'b0;
                    err0_d  = ~grant_q;
                    err1_d  = grant_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSending: begin
                if (!Tx_BUSY) begin
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    tx_en_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_wr_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            baud_q       <= 3'b111;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_wr_q      <= tx_wr_d;
            tx_en_q      <= tx_en_d;
            baud_q       <= baud_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            busy_q       <= busy_d;
        end
    end

    assign Tx_DATA     = tx_data_q;
    assign Tx_WR       = tx_wr_q;
    assign Tx_EN       = tx_en_q;
    assign baud_select = baud_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the transmitter side (Tx_BUSY) is driven by hand
// from each scenario task; inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset, req0, req1, Tx_BUSY;
    logic [7:0] data0, data1;
    logic [2:0] baud_cfg;
    logic [7:0] Tx_DATA;
    logic       Tx_WR, Tx_EN, ack0, ack1, err0, err1, busy;
    logic [2:0] baud_select;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_arbiter #(.START_TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .baud_cfg(baud_cfg), .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR),
        .Tx_EN(Tx_EN), .baud_select(baud_select), .ack0(ack0), .ack1(ack1), .err0(err0),
        .err1(err1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Steps until Tx_WR is seen high or the budget runs out.
    task automatic wait_wr(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (Tx_WR === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; Tx_BUSY = 1'b0;
        data0 = 8'h00; data1 = 8'h00; baud_cfg = 3'b111;
        step(); step();
        tests_run++; if (Tx_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got=%h exp=00", Tx_DATA); end
        tests_run++; if ({Tx_WR, Tx_EN} !== 2'b00) begin tests_failed++; $display("FAIL reset_wr_en got=%b exp=00", {Tx_WR, Tx_EN}); end
        tests_run++; if (baud_select !== 3'b111) begin tests_failed++; $display("FAIL reset_baud got=%b exp=111", baud_select); end
        tests_run++; if ({ack0, ack1, err0, err1, busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got=%b exp=00000", {ack0, ack1, err0, err1, busy}); end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        int early_acks;
        req0 = 1'b1; data0 = 8'hDD;
        step();
        tests_run++; if ({busy, Tx_WR} !== 2'b10) begin tests_failed++; $display("FAIL single_arb got busy,wr=%b exp=10", {busy, Tx_WR}); end
        step();
        tests_run++; if ({Tx_WR, Tx_EN} !== 2'b11) begin tests_failed++; $display("FAIL single_wr_rise got=%b exp=11", {Tx_WR, Tx_EN}); end
        tests_run++; if (Tx_DATA !== 8'hDD) begin tests_failed++; $display("FAIL single_data got=%h exp=dd", Tx_DATA); end
        step(); step();
        Tx_BUSY = 1'b1;
        step();
        tests_run++; if ({Tx_WR, Tx_EN} !== 2'b01) begin tests_failed++; $display("FAIL single_wr_drop got=%b exp=01", {Tx_WR, Tx_EN}); end
        early_acks = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (ack0 === 1'b1 || ack1 === 1'b1) early_acks++;
        end
        tests_run++; if (early_acks !== 0) begin tests_failed++; $display("FAIL single_no_early_ack got=%0d exp=0", early_acks); end
        tests_run++; if (Tx_DATA !== 8'hDD) begin tests_failed++; $display("FAIL single_data_held got=%h exp=dd", Tx_DATA); end
        Tx_BUSY = 1'b0;
        step();
        tests_run++; if ({ack0, ack1, Tx_EN} !== 3'b100) begin tests_failed++; $display("FAIL single_ack got ack0,ack1,en=%b exp=100", {ack0, ack1, Tx_EN}); end
        req0 = 1'b0;
        step();
        tests_run++; if ({ack0, busy} !== 2'b00) begin tests_failed++; $display("FAIL single_done got ack0,busy=%b exp=00", {ack0, busy}); end
        step();
        tests_run++; if ({busy, Tx_WR} !== 2'b00) begin tests_failed++; $display("FAIL single_idle got busy,wr=%b exp=00", {busy, Tx_WR}); end
    endtask

    task automatic test_back_to_back();
        bit found;
        int both_hi, got;
        logic [7:0] exp_data;
        reset = 1'b1; step(); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hA5; data1 = 8'h3C;
        both_hi = 0;
        for (int k = 0; k < 4; k++) begin
            exp_data = (k % 2 == 0) ? 8'hA5 : 8'h3C;
            wait_wr(found);
            tests_run++; if (!found || Tx_DATA !== exp_data) begin tests_failed++; $display("FAIL b2b_frame%0d_data got=%h wr_seen=%0d exp=%h", k, Tx_DATA, found, exp_data); end
            Tx_BUSY = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step();
                if (ack0 === 1'b1 && ack1 === 1'b1) both_hi++;
            end
            Tx_BUSY = 1'b0;
            got = -1;
            for (int i = 0; i < 5 && got < 0; i++) begin
                step();
                if (ack0 === 1'b1 && ack1 === 1'b1) both_hi++;
                else if (ack0 === 1'b1) got = 0;
                else if (ack1 === 1'b1) got = 1;
            end
            tests_run++; if (got !== k % 2) begin tests_failed++; $display("FAIL b2b_frame%0d_ack got=%0d exp=%0d", k, got, k % 2); end
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();
        tests_run++; if (both_hi !== 0) begin tests_failed++; $display("FAIL b2b_ack_exclusive got=%0d exp=0", both_hi); end
    endtask

    task automatic test_timeout();
        bit found, hit, saw_ack;
        int cyc;
        req1 = 1'b1; data1 = 8'h5A; Tx_BUSY = 1'b0;
        wait_wr(found);
        tests_run++; if (!found) begin tests_failed++; $display("FAIL timeout_wr_rise got=0 exp=1"); end
        cyc = 0; hit = 1'b0; saw_ack = 1'b0;
        while (cyc < 100 && !hit) begin
            step();
            cyc++;
            if (ack1 === 1'b1 || ack0 === 1'b1) saw_ack = 1'b1;
            if (err1 === 1'b1) hit = 1'b1;
        end
        tests_run++; if (cyc !== 64) begin tests_failed++; $display("FAIL timeout_err1_latency got=%0d exp=64", cyc); end
        tests_run++; if ({Tx_WR, Tx_EN, err0, busy} !== 4'b0000) begin tests_failed++; $display("FAIL timeout_outputs got wr,en,err0,busy=%b exp=0000", {Tx_WR, Tx_EN, err0, busy}); end
        tests_run++; if (saw_ack !== 1'b0) begin tests_failed++; $display("FAIL timeout_no_ack got=%0d exp=0", saw_ack); end
        req1 = 1'b0;
        step();
        tests_run++; if (err1 !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_pulse got=%b exp=0", err1); end
        req1 = 1'b1;
        wait_wr(found);
        tests_run++; if (!found || Tx_DATA !== 8'h5A) begin tests_failed++; $display("FAIL timeout_reserve_data got=%h wr_seen=%0d exp=5a", Tx_DATA, found); end
        Tx_BUSY = 1'b1;
        step(); step(); step();
        Tx_BUSY = 1'b0;
        step();
        tests_run++; if ({ack1, err1} !== 2'b10) begin tests_failed++; $display("FAIL timeout_reserve_ack got ack1,err1=%b exp=10", {ack1, err1}); end
        req1 = 1'b0;
        step(); step();
    endtask

    task automatic test_baud_freeze();
        bit found;
        baud_cfg = 3'b111; req0 = 1'b1; data0 = 8'h77;
        wait_wr(found);
        tests_run++; if (!found) begin tests_failed++; $display("FAIL baud_wr_rise got=0 exp=1"); end
        Tx_BUSY = 1'b1;
        step(); step();
        baud_cfg = 3'b010;
        step(); step();
        tests_run++; if (baud_select !== 3'b111) begin tests_failed++; $display("FAIL baud_frozen_sending got=%b exp=111", baud_select); end
        Tx_BUSY = 1'b0;
        step();
        tests_run++; if ({ack0, baud_select} !== {1'b1, 3'b111}) begin tests_failed++; $display("FAIL baud_at_ack got ack0,baud=%b exp=1111", {ack0, baud_select}); end
        req0 = 1'b0;
        step();
        tests_run++; if (baud_select !== 3'b111) begin tests_failed++; $display("FAIL baud_frozen_done got=%b exp=111", baud_select); end
        step();
        tests_run++; if (baud_select !== 3'b010) begin tests_failed++; $display("FAIL baud_idle_update got=%b exp=010", baud_select); end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        wait_wr(found);
        tests_run++; if (!found || Tx_DATA !== 8'h22) begin tests_failed++; $display("FAIL midrst_pre_data got=%h wr_seen=%0d exp=22", Tx_DATA, found); end
        Tx_BUSY = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        tests_run++; if ({Tx_DATA, Tx_WR, Tx_EN} !== 10'h000) begin tests_failed++; $display("FAIL midrst_tx got data,wr,en=%h,%b,%b exp=00,0,0", Tx_DATA, Tx_WR, Tx_EN); end
        tests_run++; if ({baud_select, ack0, ack1, err0, err1, busy} !== 8'b111_00000) begin tests_failed++; $display("FAIL midrst_flags got=%b exp=11100000", {baud_select, ack0, ack1, err0, err1, busy}); end
        reset = 1'b0; Tx_BUSY = 1'b0;
        wait_wr(found);
        tests_run++; if (!found || Tx_DATA !== 8'h11) begin tests_failed++; $display("FAIL midrst_first_grant got=%h wr_seen=%0d exp=11", Tx_DATA, found); end
        Tx_BUSY = 1'b1;
        step(); step();
        Tx_BUSY = 1'b0;
        step();
        tests_run++; if ({ack0, ack1} !== 2'b10) begin tests_failed++; $display("FAIL midrst_ack got ack0,ack1=%b exp=10", {ack0, ack1}); end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();
    endtask

    task automatic test_stale_busy();
        bit found;
        int early;
        reset = 1'b1; Tx_BUSY = 1'b1; req0 = 1'b1; data0 = 8'hC3;
        step();
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Tx_WR !== 1'b0 || busy !== 1'b0) early++;
        end
        tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL stale_blocked got=%0d exp=0", early); end
        Tx_BUSY = 1'b0;
        wait_wr(found);
        tests_run++; if (!found || Tx_DATA !== 8'hC3) begin tests_failed++; $display("FAIL stale_data got=%h wr_seen=%0d exp=c3", Tx_DATA, found); end
        Tx_BUSY = 1'b1;
        step(); step();
        Tx_BUSY = 1'b0;
        step();
        tests_run++; if ({ack0, ack1, err0} !== 3'b100) begin tests_failed++; $display("FAIL stale_ack got ack0,ack1,err0=%b exp=100", {ack0, ack1, err0}); end
        req0 = 1'b0;
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; Tx_BUSY = 1'b0;
        data0 = 8'h00; data1 = 8'h00; baud_cfg = 3'b111;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_timeout();
        test_baud_freeze();
        test_reset_mid_frame();
        test_stale_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
